// File: rtl/mat_sequencer.sv
// mat_sequencer: feeds a weight matrix and skewed input vectors into an NxN systolic array
// and deskews its outputs back into whole result vectors.
module mat_sequencer #(
    parameter int N        = 4,
    parameter int PIPE_LAT = 4
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_load,
    input  logic [15:0]               cmd_count,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [31:0]               in_data [N],
    output logic                      mu_load_weight,
    output logic [$clog2(2*N)-1:0]    mu_weight_progress,
    output logic [31:0]               mu_data_in [N],
    input  logic [31:0]               mu_data_out [N],
    output logic                      out_valid,
    output logic [31:0]               out_data [N]
);
    localparam int L  = PIPE_LAT + N + 1;
    localparam int KW = $clog2(2 * N);
    localparam int AW = $clog2(N);

    typedef enum logic [2:0] {IDLE, WFILL, WBURST, STREAM, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [L-1:0]  tok_q;
    logic [31:0]   w_q [N][N];
    logic          s_acc;

    assign cmd_ready          = state_q == IDLE;
    assign in_ready           = state_q == WFILL || (state_q == STREAM && cnt_q != '0);
    assign s_acc              = in_valid && in_ready && state_q == STREAM;
    assign mu_load_weight     = state_q == WBURST;
    assign mu_weight_progress = mu_load_weight ? k_q : '0;
    assign out_valid          = tok_q[L-1];

    // k counts rows during WFILL and burst steps during WBURST
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (cmd_valid) begin
                state_d = cmd_load ? WFILL : (cmd_count == '0 ? DRAIN : STREAM);
                k_d     = '0;
                cnt_d   = cmd_count;
            end
            WFILL: if (in_valid) begin
                k_d     = (k_q == KW'(N - 1)) ? '0 : k_q + 1'b1;
                state_d = (k_q == KW'(N - 1)) ? WBURST : WFILL;
            end
            WBURST: begin
                k_d     = (k_q == KW'(2 * N - 1)) ? '0 : k_q + 1'b1;
                state_d = (k_q == KW'(2 * N - 1)) ? IDLE : WBURST;
            end
            STREAM: if (s_acc) begin
                cnt_d   = cnt_q - 16'd1;
                state_d = (cnt_q == 16'd1) ? DRAIN : STREAM;
            end
            DRAIN: state_d = (tok_q[L-2:0] == '0) ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            cnt_q   <= '0;
            tok_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            tok_q   <= {tok_q[L-2:0], s_acc};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    w_q[r][c] <= '0;
        end else if (state_q == WFILL && in_valid) begin
            w_q[k_q[AW-1:0]] <= in_data;
        end
    end

    genvar i;
    for (i = 0; i < N; i++) begin : g_lane
        logic [31:0]   d_q [i+1];
        logic [31:0]   s_q [N-i];
        logic [KW-1:0] r;
        // input skew of i+1 cycles, output deskew of N-i cycles: every lane totals N+1
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                for (int s = 0; s <= i; s++) d_q[s] <= '0;
                for (int s = 0; s < N - i; s++) s_q[s] <= '0;
            end else begin
                d_q[0] <= s_acc ? in_data[i] : '0;
                for (int s = 1; s <= i; s++) d_q[s] <= d_q[s-1];
                s_q[0] <= mu_data_out[i];
                for (int s = 1; s < N - i; s++) s_q[s] <= s_q[s-1];
            end
        end
        assign r             = k_q - KW'(i);
        assign mu_data_in[i] = mu_load_weight
                             ? ((k_q >= KW'(i) && r < KW'(N)) ? w_q[r[AW-1:0]][i] : '0)
                             : d_q[i];
        assign out_data[i]   = s_q[N-i-1];
    end
endmodule

// File: tb/tb_mat_sequencer.sv
// tb_mat_sequencer: directed bench with a stub array (pure PIPE_LAT delay) and a
// scoreboard of expected result vectors keyed by the cycle they must appear.
module tb_mat_sequencer;
    localparam int N  = 4;
    localparam int P  = 4;
    localparam int L  = P + N + 1;
    localparam int KW = $clog2(2 * N);

    logic              clock = 0, reset_n = 0, cmd_valid = 0, cmd_load = 0, in_valid = 0;
    logic [15:0]       cmd_count = '0;
    logic [31:0]       in_data [N];
    logic              cmd_ready, in_ready, mu_load_weight, out_valid;
    logic [KW-1:0]     mu_weight_progress;
    logic [31:0]       mu_data_in [N], mu_data_out [N], out_data [N];
    logic [31:0]       pipe [P][N];
    logic [31:0]       vin [8][N];
    int                due_q [$];
    logic [N*32-1:0]   dat_q [$];
    int                cyc = 0, tests = 0, fails = 0;

    mat_sequencer #(.N(N), .PIPE_LAT(P)) dut (
        .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_load(cmd_load), .cmd_count(cmd_count), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .mu_load_weight(mu_load_weight),
        .mu_weight_progress(mu_weight_progress), .mu_data_in(mu_data_in),
        .mu_data_out(mu_data_out), .out_valid(out_valid), .out_data(out_data)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        if (!reset_n) begin
            for (int p = 0; p < P; p++)
                for (int i = 0; i < N; i++) pipe[p][i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) pipe[0][i] <= mu_data_in[i];
            for (int p = 1; p < P; p++) pipe[p] <= pipe[p-1];
        end
    end
    always_comb for (int i = 0; i < N; i++) mu_data_out[i] = pipe[P-1][i];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, req);
        end
    endtask

    always @(negedge clock) begin
        if (reset_n) begin
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                check("out_valid result", {31'd0, out_valid}, 1);
                for (int i = 0; i < N; i++)
                    check($sformatf("out_data[%0d]", i), out_data[i], dat_q[0][i*32 +: 32]);
                void'(due_q.pop_front());
                void'(dat_q.pop_front());
            end else begin
                check("out_valid quiet", {31'd0, out_valid}, 0);
            end
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        check({tag, " cmd_ready"}, {31'd0, cmd_ready}, 1);
        check({tag, " in_ready"}, {31'd0, in_ready}, 0);
        check({tag, " load_weight"}, {31'd0, mu_load_weight}, 0);
        check({tag, " progress"}, {29'd0, mu_weight_progress}, 0);
        check({tag, " out_valid"}, {31'd0, out_valid}, 0);
        for (int i = 0; i < N; i++) check($sformatf("%s mu_data_in[%0d]", tag, i), mu_data_in[i], 0);
    endtask

    // rows W[r][i] = 10r+i with one bubble before row 2; optional reset at burst step stop_k
    task automatic wload(input int stop_k);
        logic [31:0] k3 [N] = '{32'd30, 32'd21, 32'd12, 32'd3};
        cmd_valid = 1; cmd_load = 1;
        check("wl cmd_ready", {31'd0, cmd_ready}, 1);
        tick;
        cmd_valid = 0;
        for (int r = 0; r < N; r++) begin
            if (r == 2) begin
                in_valid = 0;
                check("wfill bubble in_ready", {31'd0, in_ready}, 1);
                tick;
            end
            in_valid = 1;
            for (int i = 0; i < N; i++) in_data[i] = 10 * r + i;
            check("wfill in_ready", {31'd0, in_ready}, 1);
            tick;
        end
        in_valid = 0;
        for (int k = 0; k < 2 * N; k++) begin
            check("burst load_weight", {31'd0, mu_load_weight}, 1);
            check("burst progress", {29'd0, mu_weight_progress}, k);
            for (int i = 0; i < N; i++)
                check($sformatf("burst k%0d lane%0d", k, i), mu_data_in[i],
                      (k - i >= 0 && k - i < N) ? 10 * (k - i) + i : 0);
            if (k == 3) for (int i = 0; i < N; i++) check("burst k3 literal", mu_data_in[i], k3[i]);
            if (k == 7) for (int i = 0; i < N; i++) check("burst k7 literal", mu_data_in[i], 0);
            if (k == stop_k) begin
                reset_n = 0;
                due_q.delete();
                dat_q.delete();
                #1;
                chk_idle("async reset");
                return;
            end
            tick;
        end
        check("after burst load_weight", {31'd0, mu_load_weight}, 0);
        check("after burst cmd_ready", {31'd0, cmd_ready}, 1);
        check("after burst progress", {29'd0, mu_weight_progress}, 0);
    endtask

    task automatic compute(input int c, input logic [7:0] pat, input bit skew);
        int acc = 0, s = 0, last = -1, n = 0;
        logic [N*32-1:0] pk;
        cmd_valid = 1; cmd_load = 0; cmd_count = c[15:0];
        check("cmp cmd_ready", {31'd0, cmd_ready}, 1);
        tick;
        cmd_valid = 0;
        if (c == 0) begin
            check("zero cmd_ready t+1", {31'd0, cmd_ready}, 0);
            check("zero in_ready t+1", {31'd0, in_ready}, 0);
            tick;
            check("zero cmd_ready t+2", {31'd0, cmd_ready}, 1);
            check("zero in_ready t+2", {31'd0, in_ready}, 0);
            return;
        end
        while (acc < c && s < 8) begin
            in_valid = pat[s];
            check("stream in_ready", {31'd0, in_ready}, 1);
            for (int i = 0; i < N; i++) in_data[i] = pat[s] ? vin[acc][i] : '0;
            if (pat[s]) begin
                for (int i = 0; i < N; i++) pk[i*32 +: 32] = vin[acc][i];
                due_q.push_back(cyc + L);
                dat_q.push_back(pk);
                last = cyc;
                acc++;
            end
            tick;
            s++;
        end
        in_valid = 0;
        check("stream accepts", acc, c);
        if (skew) begin
            for (int d = 1; d <= N; d++) begin
                for (int i = 0; i < N; i++)
                    check($sformatf("skew t+%0d lane%0d", d, i), mu_data_in[i],
                          (i == d - 1) ? vin[0][i] : 0);
                tick;
            end
            while (cyc < last + 9) tick;
            check("single out_valid t+9", {31'd0, out_valid}, 1);
            check("single lane0 literal", out_data[0], 32'h3f800000);
            check("single lane3 literal", out_data[3], 32'h40800000);
        end
        while (!cmd_ready && n < 40) begin
            check("drain in_ready", {31'd0, in_ready}, 0);
            tick;
            n++;
        end
        check("idle after last accept", cyc - last, L + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < N; i++) in_data[i] = '0;
        repeat (3) @(posedge clock);
        #1;
        chk_idle("in reset");
        reset_n = 1;
        tick;
        chk_idle("after reset");

        wload(-1);

        vin[0] = '{32'h3f800000, 32'h40000000, 32'h40400000, 32'h40800000};
        compute(1, 8'b1, 1);

        for (int k = 0; k < 3; k++)
            for (int i = 0; i < N; i++) vin[k][i] = 32'h100 * (k + 1) + i + 1;
        compute(3, 8'b111, 0);

        for (int k = 0; k < 2; k++)
            for (int i = 0; i < N; i++) vin[k][i] = 32'h5000 + 32'h10 * k + i;
        compute(2, 8'b101, 0);

        compute(0, 8'b0, 0);

        wload(4);
        tick;
        tick;
        reset_n = 1;
        check("release cmd_ready", {31'd0, cmd_ready}, 1);
        tick;
        chk_idle("after mid reset");
        vin[0] = '{32'd1, 32'd2, 32'd3, 32'd4};
        compute(1, 8'b1, 0);

        repeat (3) tick;
        check("scoreboard drained", due_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mat_sequencer.md
# mat_sequencer

Sequencer in front of the `MatUnit` N×N systolic array.
- Accepts weight-load and compute commands over a valid/ready interface.
- Buffers one full weight matrix, then replays it into the array as a skewed `load_weight`/`weight_progress` burst.
- Streams input vectors into the array with per-lane diagonal skew.
- Deskews the array outputs back into whole result vectors.
- Data lanes carry 32-bit `shortreal` bit patterns; the block never does arithmetic on them.

## Interface
- `N`, 4: array dimension (lanes).
- `PIPE_LAT`, 4: cycles from `mu_data_in[0]` to the matching `mu_data_out[0]` inside the array.
- `clock` in 1: the only clock; all logic on posedge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_load` in 1: 1 = weight load, 0 = compute.
- `cmd_count` in 16: number of vectors in a compute command; ignored for weight loads.
- `in_valid` in 1: input row/vector present.
- `in_ready` out 1: row/vector accepted when `in_valid && in_ready`.
- `in_data[N]` in 32 each: weight row or input vector.
- `mu_load_weight` out 1: drives `MatUnit.load_weight`.
- `mu_weight_progress` out `$clog2(2N)`: drives `MatUnit.weight_progress`.
- `mu_data_in[N]` out 32 each: drives `MatUnit.data_in`.
- `mu_data_out[N]` in 32 each: from `MatUnit.data_out`.
- `out_valid` out 1: result vector valid. There is no backpressure; the consumer must take it that cycle.
- `out_data[N]` out 32 each: deskewed result vector.

## Operation
- **FSM states:** IDLE, WFILL, WBURST, STREAM, DRAIN.
- **IDLE:**
  - `cmd_ready`=1, `in_ready`=0, `mu_load_weight`=0, `mu_data_in`=0.
  - A command handshake at cycle t moves to WFILL (`cmd_load`=1) or STREAM (`cmd_load`=0) at t+1.
  - `cmd_count`=0 goes to DRAIN, which returns to IDLE after 1 cycle with no `out_valid`.
- **WFILL:**
  - `in_ready`=1; accepted rows are stored in order as W[0..N-1] in an internal N×N buffer.
  - After the N-th accept, go to WBURST next cycle.
  - Bubbles on `in_valid` are allowed and simply wait.
- **WBURST:** exactly 2N cycles, k=0..2N-1.
  - `mu_load_weight`=1, `mu_weight_progress`=k.
  - `mu_data_in[i]` = W[k−i][i] when 0≤k−i<N, else 0.
  - Then go to IDLE; `mu_load_weight` drops to 0 that cycle.
- **STREAM:**
  - `in_ready`=1 while remaining count >0. Each accept decrements the count; on the last accept, go to DRAIN.
  - Lane i of a vector accepted at cycle t is driven on `mu_data_in[i]` at t+1+i (lane i delay line of depth i+1).
  - An `in_valid`=0 cycle injects zeros and a valid=0 token.
- **Deskew:**
  - `mu_data_out[j]` is sampled and delayed N−j cycles, so all lanes of a vector align.
  - A valid-token shift register of length L = PIPE_LAT+N+1 marks which aligned words are real results.
- **DRAIN:**
  - `in_ready`=0.
  - Stay until the valid-token shift register is all zero, then go to IDLE.
  - Lanes keep shifting zeros in.
- Compute without a prior weight load is legal; it uses whatever the array holds.
- The weight buffer persists across commands and is overwritten only by WFILL.

## Timing
- **Reset values:** `cmd_ready`=1; every other output and all delay lines, tokens and the weight buffer are 0; state is IDLE.
- **Reset mid-operation:** the command is aborted, no further `out_valid`, and the block is in IDLE on the first edge after release.
- **Compute latency:** a vector accepted at t gives `out_valid`=1 at t+L (L = PIPE_LAT+N+1), all N lanes at once.
- **Throughput:** one vector per cycle.
- **Result order and bubbles:** results leave in acceptance order; input bubbles appear as `out_valid`=0 cycles at the same offset.
- **Weight-load duration:** from command handshake to IDLE is N rows (at least N cycles) + 2N burst cycles.
- **Compute duration:** a command with count C and no bubbles returns to IDLE L+1 cycles after its last accept.
- **Command handshake:** `cmd_ready` is combinational from state=IDLE. A new command may be accepted on the first IDLE cycle.
- **`mu_weight_progress` width:** wraps only by burst end (k never exceeds 2N−1). It is 0 outside WBURST.

## Test plan
Bench uses a stub array: `mu_data_out[j]` = `mu_data_in[j]` delayed PIPE_LAT cycles. One integration run uses the real `MatUnit`.
- **Weight load:** rows W[r][i]=10r+i (N=4).
  - Expect `mu_load_weight`=1 for exactly 8 cycles with progress 0..7.
  - At k=3, expect `mu_data_in` = (30,21,12,3).
  - At k=7, expect all lanes 0.
- **Single vector:** (1.0,2.0,3.0,4.0) accepted at t.
  - `mu_data_in[i]` is nonzero only at t+1+i.
  - `out_valid` at t+9 with `out_data` = (1.0,2.0,3.0,4.0) under the stub.
- **Burst:** `cmd_count`=3, back-to-back vectors.
  - Three consecutive `out_valid` cycles in order.
  - `cmd_ready` back at 1 exactly L+1 cycles after the last accept.
- **Bubbles:** count 2 with one `in_valid`=0 gap.
  - `out_valid` pattern is 1,0,1.
  - No data from the zero bubble appears with `out_valid`=1.
- **Zero-count command:** `cmd_count`=0.
  - No `in_ready`, no `out_valid`.
  - `cmd_ready` returns after 2 cycles.
- **Reset mid-operation:** `reset_n` low during WBURST k=4, then a compute.
  - All outputs are 0 immediately and `cmd_ready`=1.
  - With the real array loaded with identity weights, input (1,2,3,4) → output (1,2,3,4).
